// File: rtl/rr_request_arbiter_8.sv
// Eight-source round-robin arbiter feeding the 8-to-3 encoder. Sticky requests
// are latched into pending. One-hot grant is held until ack or hold timeout.
module rr_request_arbiter_8 #(
   parameter int unsigned MAX_HOLD = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic       ack,
   output logic [7:0] grant,
   output logic       enable,
   output logic [7:0] pending,
   output logic       timeout
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam bit         HOLD_EN   = (MAX_HOLD != 0);
   localparam logic [7:0] HOLD_LAST = HOLD_EN ? 8'(MAX_HOLD - 1) : 8'd0;

   state_t     state;
   logic [2:0] ptr;
   logic [2:0] gidx;
   logic [7:0] hold_cnt;
   logic [7:0] clr;
   logic [2:0] win_idx;
   logic [2:0] scan;
   logic       win_vld;

   // Walk downward in offset so the set bit closest to ptr is the last one written.
   always_comb begin
      win_vld = 1'b0;
      win_idx = ptr;
      scan    = ptr;
      for (int i = 7; i >= 0; i--) begin
         scan = ptr + 3'(i);
         if (pending[scan]) begin
            win_vld = 1'b1;
            win_idx = scan;
         end
      end
   end

   // Only an ack while granting clears anything; req still wins in the OR below.
   assign clr = (state == GRANT && ack) ? grant : 8'h00;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         grant    <= 8'h00;
         enable   <= 1'b0;
         pending  <= 8'h00;
         timeout  <= 1'b0;
         ptr      <= 3'd0;
         gidx     <= 3'd0;
         hold_cnt <= 8'd0;
      end else begin
         pending <= (pending & ~clr) | req;
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (win_vld) begin
                  grant    <= 8'h01 << win_idx;
                  enable   <= 1'b1;
                  gidx     <= win_idx;
                  hold_cnt <= 8'd0;
                  state    <= GRANT;
               end
            end
            GRANT: begin
               if (ack) begin
                  grant  <= 8'h00;
                  enable <= 1'b0;
                  ptr    <= gidx + 3'd1;
                  state  <= IDLE;
               end else if (HOLD_EN && hold_cnt == HOLD_LAST) begin
                  // Drop without clearing pending so the source retries later.
                  grant   <= 8'h00;
                  enable  <= 1'b0;
                  ptr     <= gidx + 3'd1;
                  timeout <= 1'b1;
                  state   <= IDLE;
               end else if (hold_cnt != 8'hFF) begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rr_request_arbiter_8.sv
// Directed bench for rr_request_arbiter_8: reset, single request, rotation,
// set-wins on ack, hold timeout and disabled timeout.
module tb_rr_request_arbiter_8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req_a = 8'h00, req_b = 8'h00, req_c = 8'h00;
   logic       ack_a = 1'b0, ack_b = 1'b0, ack_c = 1'b0;
   logic [7:0] grant_a, grant_b, grant_c;
   logic [7:0] pend_a, pend_b, pend_c;
   logic       en_a, en_b, en_c;
   logic       to_a, to_b, to_c;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   rr_request_arbiter_8 u_a (
      .clk(clk), .rst(rst), .req(req_a), .ack(ack_a),
      .grant(grant_a), .enable(en_a), .pending(pend_a), .timeout(to_a));

   rr_request_arbiter_8 #(.MAX_HOLD(4)) u_b (
      .clk(clk), .rst(rst), .req(req_b), .ack(ack_b),
      .grant(grant_b), .enable(en_b), .pending(pend_b), .timeout(to_b));

   rr_request_arbiter_8 #(.MAX_HOLD(0)) u_c (
      .clk(clk), .rst(rst), .req(req_c), .ack(ack_c),
      .grant(grant_c), .enable(en_c), .pending(pend_c), .timeout(to_c));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rst_pulse();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      step();
   endtask

   logic [7:0] rr_exp [4];
   int         hold_bad;
   int         to_seen;

   initial begin
      rr_exp[0] = 8'h02; rr_exp[1] = 8'h10; rr_exp[2] = 8'h80; rr_exp[3] = 8'h02;

      // reset state
      step(); step();
      chk("rst_grant", grant_a, 8'h00);
      chk("rst_en", en_a, 1'b0);
      chk("rst_pend", pend_a, 8'h00);
      chk("rst_to", to_a, 1'b0);
      rst = 1'b0;

      // reset mid-run with all requests asserted
      req_a = 8'hFF;
      step(); step();
      chk("pre_rst_grant", grant_a, 8'h01);
      rst = 1'b1;
      #1;
      chk("midrst_grant", grant_a, 8'h00);
      chk("midrst_en", en_a, 1'b0);
      chk("midrst_pend", pend_a, 8'h00);
      req_a = 8'h00;
      step();
      rst = 1'b0;
      step(); step();
      chk("postrst_grant", grant_a, 8'h00);
      chk("postrst_pend", pend_a, 8'h00);

      // single request pulse
      req_a = 8'h04;
      step();
      chk("single_pend", pend_a, 8'h04);
      chk("single_nogrant", grant_a, 8'h00);
      req_a = 8'h00;
      step();
      chk("single_grant", grant_a, 8'h04);
      chk("single_en", en_a, 1'b1);
      ack_a = 1'b1;
      step();
      ack_a = 1'b0;
      chk("single_ack_grant", grant_a, 8'h00);
      chk("single_ack_en", en_a, 1'b0);
      chk("single_ack_pend", pend_a, 8'h00);

      // round robin with held requests, from a fresh pointer
      rst_pulse();
      req_a = 8'h92;
      step();
      step();
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("rr_grant%0d", k), grant_a, rr_exp[k]);
         chk($sformatf("rr_en%0d", k), en_a, 1'b1);
         step();
         chk($sformatf("rr_hold%0d", k), grant_a, rr_exp[k]);
         ack_a = 1'b1;
         step();
         ack_a = 1'b0;
         chk($sformatf("rr_idle%0d", k), grant_a, 8'h00);
         chk($sformatf("rr_idle_pend%0d", k), pend_a, 8'h92);
         step();
      end
      req_a = 8'h00;

      // set-wins: req[3] on the same edge its grant is acked
      rst_pulse();
      req_a = 8'h08;
      step();
      req_a = 8'h00;
      step();
      chk("sw_grant", grant_a, 8'h08);
      req_a = 8'h41;
      step();
      req_a = 8'h08;
      ack_a = 1'b1;
      step();
      req_a = 8'h00;
      ack_a = 1'b0;
      chk("sw_pend", pend_a, 8'h49);
      chk("sw_drop", grant_a, 8'h00);
      step();
      chk("sw_next6", grant_a, 8'h40);
      ack_a = 1'b1;
      step();
      ack_a = 1'b0;
      chk("sw_pend2", pend_a, 8'h09);
      step();
      chk("sw_next0", grant_a, 8'h01);
      ack_a = 1'b1;
      step();
      ack_a = 1'b0;
      step();
      chk("sw_regrant3", grant_a, 8'h08);
      ack_a = 1'b1;
      step();
      ack_a = 1'b0;
      chk("sw_empty", pend_a, 8'h00);

      // hold timeout with MAX_HOLD=4
      req_b = 8'h01;
      step();
      req_b = 8'h00;
      step();
      chk("to_grant", grant_b, 8'h01);
      chk("to_nopulse", to_b, 1'b0);
      req_b = 8'h20;
      hold_bad = 0;
      for (int k = 1; k < 4; k++) begin
         step();
         req_b = 8'h00;
         if (grant_b !== 8'h01 || to_b !== 1'b0) hold_bad++;
      end
      chk("to_held4", hold_bad, 0);
      step();
      chk("to_drop", grant_b, 8'h00);
      chk("to_en", en_b, 1'b0);
      chk("to_pulse", to_b, 1'b1);
      chk("to_pend", pend_b, 8'h21);
      step();
      chk("to_pulse_once", to_b, 1'b0);
      chk("to_ptr_bit5", grant_b, 8'h20);
      ack_b = 1'b1;
      step();
      ack_b = 1'b0;
      chk("to_pend_after", pend_b, 8'h01);
      step();
      chk("to_bit0_back", grant_b, 8'h01);

      // timeout disabled: grant held indefinitely
      req_c = 8'h80;
      step();
      req_c = 8'h00;
      step();
      chk("nt_grant", grant_c, 8'h80);
      hold_bad = 0;
      to_seen = 0;
      for (int k = 0; k < 300; k++) begin
         step();
         if (grant_c !== 8'h80 || en_c !== 1'b1) hold_bad++;
         if (to_c) to_seen++;
      end
      chk("nt_held300", hold_bad, 0);
      chk("nt_no_timeout", to_seen, 0);
      chk("nt_grant_end", grant_c, 8'h80);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
